// File: rtl/memblk_pkg.sv
// Shared memblk lane constants and the lane request record used by lane arbiters.
package memblk_pkg;

  localparam int AW      = 39;
  localparam int PW      = 40;
  localparam int DW      = 533;
  localparam int MAX_OUT = 48;
  localparam int OUTW    = 6;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [PW-1:0] phy;
    logic [DW-1:0] wdata;
  } lane_req_t;

endpackage

// File: rtl/memblk_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each read still inside memblk.
module memblk_tag_fifo #(
  parameter int DEPTH = 48,
  parameter int W     = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PTRW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]    mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Tag storage carries no reset; only the pointers decide what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/memblk_lane_arb.sv
// Round-robin sharing of one memblk rd/wr lane among NREQ requesters,
// with read returns routed back to their issuer through an in-order tag FIFO.
module memblk_lane_arb
  import memblk_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MAX_OUT = memblk_pkg::MAX_OUT,
  parameter int AW      = memblk_pkg::AW,
  parameter int PW      = memblk_pkg::PW,
  parameter int DW      = memblk_pkg::DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*PW-1:0] req_phy,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   req_grant,
  input  logic              mb_stall,
  output logic [AW-1:0]     mb_rdaddr0,
  output logic [PW-1:0]     mb_rdphydata0,
  output logic              mb_rden_in,
  output logic [AW-1:0]     mb_wraddr0,
  output logic [DW-1:0]     mb_wrdata,
  output logic              mb_wren_in,
  input  logic              mb_rden_out,
  input  logic [DW-1:0]     mb_rddata,
  output logic [NREQ-1:0]   resp_valid,
  output logic [DW-1:0]     resp_data,
  output logic [5:0]        outstanding,
  output logic              err_underflow
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MAX_OUT + 1);

  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  slot_id;
  logic [IDW-1:0]  pop_id;
  logic [NREQ-1:0] eligible;
  logic            found;
  logic            grant_fire;
  logic            slot_valid;
  logic            slot_ready;
  logic            credit_ok;
  logic            push;
  logic            pop;
  logic            ret_fire;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  lane_req_t       win_req;

  function automatic logic [IDW-1:0] rr_after(input logic [IDW-1:0] id);
    return (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
    return NREQ'(1) << id;
  endfunction

  assign slot_valid = mb_rden_in | mb_wren_in;
  assign slot_ready = !slot_valid || !mb_stall;
  // A read parked in the slot already holds a credit, even before memblk takes it.
  assign credit_ok  = (int'(fifo_count) + int'(mb_rden_in)) < MAX_OUT;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] && (req_we[i] || credit_ok);
    end
  end

  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && eligible[(int'(rr_ptr) + k) % NREQ]) begin
        found  = 1'b1;
        win_id = IDW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    win_req.we    = req_we[win_id];
    win_req.addr  = req_addr[int'(win_id)*AW +: AW];
    win_req.phy   = req_phy[int'(win_id)*PW +: PW];
    win_req.wdata = req_wdata[int'(win_id)*DW +: DW];
  end

  assign grant_fire = slot_ready && found && !rst;
  assign req_grant  = grant_fire ? onehot(win_id) : '0;

  // Stage p0 -> p1: winner registered into the lane slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mb_rden_in    <= 1'b0;
      mb_wren_in    <= 1'b0;
      slot_id       <= '0;
      rr_ptr        <= '0;
      mb_rdaddr0    <= '0;
      mb_rdphydata0 <= '0;
      mb_wraddr0    <= '0;
      mb_wrdata     <= '0;
    end else if (slot_ready) begin
      if (grant_fire) begin
        mb_rden_in <= !win_req.we;
        mb_wren_in <= win_req.we;
        slot_id    <= win_id;
        rr_ptr     <= rr_after(win_id);
        if (win_req.we) begin
          mb_wraddr0 <= win_req.addr;
          mb_wrdata  <= win_req.wdata;
        end else begin
          mb_rdaddr0    <= win_req.addr;
          mb_rdphydata0 <= win_req.phy;
        end
      end else begin
        mb_rden_in <= 1'b0;
        mb_wren_in <= 1'b0;
      end
    end
  end

  assign push     = mb_rden_in && !mb_stall;
  assign ret_fire = mb_rden_out && !mb_stall;
  assign pop      = ret_fire && !fifo_empty;

  memblk_tag_fifo #(
    .DEPTH (MAX_OUT),
    .W     (IDW)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (slot_id),
    .pop       (pop),
    .pop_data  (pop_id),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Return stage: popped tag steers the line to its requester one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid    <= '0;
      resp_data     <= '0;
      err_underflow <= 1'b0;
    end else begin
      resp_valid <= pop ? onehot(pop_id) : '0;
      if (pop) resp_data <= mb_rddata;
      if (ret_fire && fifo_empty) err_underflow <= 1'b1;
    end
  end

  assign outstanding = 6'(fifo_count);

endmodule

// File: tb/tb_memblk_lane_arb.sv
// Bench for memblk_lane_arb: transaction-level model (rotation, credits, tag queue)
// compared every cycle, plus directed scenarios with literal expectations.
module tb_memblk_lane_arb;

  localparam int NREQ    = 4;
  localparam int AW      = 39;
  localparam int PW      = 40;
  localparam int DW      = 533;
  localparam int MAX_OUT = 48;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*PW-1:0] req_phy;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   req_grant;
  logic              mb_stall;
  logic [AW-1:0]     mb_rdaddr0;
  logic [PW-1:0]     mb_rdphydata0;
  logic              mb_rden_in;
  logic [AW-1:0]     mb_wraddr0;
  logic [DW-1:0]     mb_wrdata;
  logic              mb_wren_in;
  logic              mb_rden_out;
  logic [DW-1:0]     mb_rddata;
  logic [NREQ-1:0]   resp_valid;
  logic [DW-1:0]     resp_data;
  logic [5:0]        outstanding;
  logic              err_underflow;

  memblk_lane_arb #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_phy(req_phy), .req_wdata(req_wdata), .req_grant(req_grant),
    .mb_stall(mb_stall),
    .mb_rdaddr0(mb_rdaddr0), .mb_rdphydata0(mb_rdphydata0), .mb_rden_in(mb_rden_in),
    .mb_wraddr0(mb_wraddr0), .mb_wrdata(mb_wrdata), .mb_wren_in(mb_wren_in),
    .mb_rden_out(mb_rden_out), .mb_rddata(mb_rddata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: what the lane must look like after the last edge.
  int              m_rr;
  bit              s_valid, s_read;
  int              s_id;
  logic [AW-1:0]   m_rdaddr, m_wraddr;
  logic [PW-1:0]   m_phy;
  logic [DW-1:0]   m_wdata;
  int              tagq[$];
  logic [NREQ-1:0] m_resp_v;
  logic [DW-1:0]   m_resp_d;
  bit              m_err;
  int              m_win;
  bit              m_ready;
  logic [NREQ-1:0] g_last;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [543:0] t;
    for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
    return t[DW-1:0];
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[AW-1:0];
  endfunction

  function automatic logic [PW-1:0] rand_phy();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[PW-1:0];
  endfunction

  task automatic model_reset();
    m_rr = 0; s_valid = 0; s_read = 0; s_id = 0;
    m_rdaddr = '0; m_wraddr = '0; m_phy = '0; m_wdata = '0;
    tagq.delete();
    m_resp_v = '0; m_resp_d = '0; m_err = 0;
  endtask

  task automatic mcheck();
    logic [NREQ-1:0] exp_g;
    int sz;
    bit credit;
    sz      = tagq.size();
    m_ready = !s_valid || !mb_stall;
    credit  = (sz + ((s_valid && s_read) ? 1 : 0)) < MAX_OUT;
    m_win   = -1;
    if (m_ready) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_rr + k) % NREQ;
        if (m_win < 0 && req_valid[i] && (req_we[i] || credit)) m_win = i;
      end
    end
    exp_g  = (m_win >= 0) ? (NREQ'(1) << m_win) : '0;
    g_last = req_grant;
    chk("req_grant",     DW'(req_grant),     DW'(exp_g));
    chk("mb_rden_in",    DW'(mb_rden_in),    DW'(s_valid && s_read));
    chk("mb_wren_in",    DW'(mb_wren_in),    DW'(s_valid && !s_read));
    chk("mb_rdaddr0",    DW'(mb_rdaddr0),    DW'(m_rdaddr));
    chk("mb_rdphydata0", DW'(mb_rdphydata0), DW'(m_phy));
    chk("mb_wraddr0",    DW'(mb_wraddr0),    DW'(m_wraddr));
    chk("mb_wrdata",     mb_wrdata,          m_wdata);
    chk("resp_valid",    DW'(resp_valid),    DW'(m_resp_v));
    chk("resp_data",     resp_data,          m_resp_d);
    chk("outstanding",   DW'(outstanding),   DW'(sz));
    chk("err_underflow", DW'(err_underflow), DW'(m_err));
  endtask

  task automatic mupdate();
    bit was_empty;
    int id;
    was_empty = (tagq.size() == 0);
    m_resp_v  = '0;
    if (mb_rden_out && !mb_stall) begin
      if (was_empty) m_err = 1;
      else begin
        id = tagq.pop_front();
        m_resp_v = NREQ'(1) << id;
        m_resp_d = mb_rddata;
      end
    end
    if (s_valid && s_read && !mb_stall) begin
      chk("credit_bound", DW'(tagq.size() < MAX_OUT), DW'(1));
      tagq.push_back(s_id);
    end
    if (m_ready) begin
      if (m_win >= 0) begin
        s_valid = 1;
        s_read  = !req_we[m_win];
        s_id    = m_win;
        if (req_we[m_win]) begin
          m_wraddr = req_addr[m_win*AW +: AW];
          m_wdata  = req_wdata[m_win*DW +: DW];
        end else begin
          m_rdaddr = req_addr[m_win*AW +: AW];
          m_phy    = req_phy[m_win*PW +: PW];
        end
        m_rr = (m_win + 1) % NREQ;
      end else begin
        s_valid = 0;
      end
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    #2;
    mcheck();
    @(posedge clk);
    #1;
    mupdate();
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = '0; req_we = '0; mb_stall = 0; mb_rden_out = 0;
  endtask

  task automatic set_req(int i, bit we, logic [AW-1:0] a);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i*AW +: AW]  = a;
    req_phy[i*PW +: PW]   = rand_phy();
    req_wdata[i*DW +: DW] = rand_line();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_grant"},   DW'(req_grant),     '0);
    chk({tag, "_rden"},    DW'(mb_rden_in),    '0);
    chk({tag, "_wren"},    DW'(mb_wren_in),    '0);
    chk({tag, "_rdaddr"},  DW'(mb_rdaddr0),    '0);
    chk({tag, "_phy"},     DW'(mb_rdphydata0), '0);
    chk({tag, "_wraddr"},  DW'(mb_wraddr0),    '0);
    chk({tag, "_wrdata"},  mb_wrdata,          '0);
    chk({tag, "_rvalid"},  DW'(resp_valid),    '0);
    chk({tag, "_rdata"},   resp_data,          '0);
    chk({tag, "_outst"},   DW'(outstanding),   '0);
    chk({tag, "_err"},     DW'(err_underflow), '0);
  endtask

  // Asserts reset dly time units after the current negedge, checks it took effect immediately.
  task automatic do_reset(int dly, string tag);
    #(dly);
    rst = 1'b1;
    #1;
    chk_zero(tag);
    model_reset();
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_inputs(int ret_pct, int stall_pct, int req_pct);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = ($urandom_range(99) < req_pct);
      req_we[i]    = $urandom_range(1);
      req_addr[i*AW +: AW]  = rand_addr();
      req_phy[i*PW +: PW]   = rand_phy();
      req_wdata[i*DW +: DW] = rand_line();
    end
    mb_stall    = ($urandom_range(99) < stall_pct);
    mb_rden_out = (tagq.size() > 0) && ($urandom_range(99) < ret_pct);
    mb_rddata   = rand_line();
  endtask

  initial begin
    int cnt[NREQ];
    int first[5];
    logic [NREQ-1:0] rseq[4];
    logic [DW-1:0] rd;

    rst = 1'b1;
    req_addr = '0; req_phy = '0; req_wdata = '0; mb_rddata = '0;
    idle();
    model_reset();
    #1;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single read from requester 2.
    set_req(2, 1'b0, 39'h40);
    tick();
    chk("t1_grant", DW'(g_last), DW'(4'b0100));
    idle();
    chk("t1_rden", DW'(mb_rden_in), DW'(1'b1));
    chk("t1_rdaddr", DW'(mb_rdaddr0), DW'(39'h40));
    tick();
    chk("t1_outst1", DW'(outstanding), DW'(6'd1));
    for (int i = 0; i < 46; i++) tick();
    rd = rand_line();
    mb_rden_out = 1'b1;
    mb_rddata   = rd;
    tick();
    idle();
    chk("t1_resp_v", DW'(resp_valid), DW'(4'b0100));
    chk("t1_resp_d", resp_data, rd);
    chk("t1_outst0", DW'(outstanding), DW'(6'd0));

    // All four requesters writing continuously.
    do_reset(0, "rst2");
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    for (int t = 0; t < 100; t++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, rand_addr());
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (g_last[i]) begin
          cnt[i]++;
          if (t < 5) first[t] = i;
        end
      end
    end
    idle();
    for (int i = 0; i < NREQ; i++) chk("t2_count", DW'(cnt[i]), DW'(25));
    for (int t = 0; t < 5; t++) chk("t2_order", DW'(first[t]), DW'(t % NREQ));

    // Stall holding a read in the slot.
    do_reset(0, "rst3");
    set_req(1, 1'b0, 39'h1234);
    tick();
    idle();
    set_req(0, 1'b1, rand_addr());
    set_req(2, 1'b1, rand_addr());
    mb_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_no_grant", DW'(g_last), '0);
      chk("t3_hold_rden", DW'(mb_rden_in), DW'(1'b1));
      chk("t3_hold_addr", DW'(mb_rdaddr0), DW'(39'h1234));
      chk("t3_no_push", DW'(outstanding), '0);
    end
    mb_stall = 1'b0;
    tick();
    chk("t3_release_grant", DW'(g_last), DW'(4'b0100));
    chk("t3_push", DW'(outstanding), DW'(6'd1));
    chk("t3_next_wr", DW'(mb_wren_in), DW'(1'b1));
    idle();
    tick();
    tick();
    mb_rden_out = 1'b1;
    tick();
    idle();

    // Credit exhaustion: reads block, writes pass.
    do_reset(0, "rst4");
    set_req(0, 1'b0, rand_addr());
    for (int i = 0; i < 55; i++) tick();
    chk("t4_full", DW'(outstanding), DW'(6'd48));
    chk("t4_slot_clear", DW'(mb_rden_in), '0);
    set_req(1, 1'b1, rand_addr());
    tick();
    chk("t4_write_only", DW'(g_last), DW'(4'b0010));
    req_valid[1] = 1'b0;
    mb_rden_out = 1'b1;
    mb_rddata   = rand_line();
    tick();
    chk("t4_blocked", DW'(g_last), '0);
    mb_rden_out = 1'b0;
    tick();
    chk("t4_read_after_ret", DW'(g_last), DW'(4'b0001));
    idle();
    for (int i = 0; i < 100 && (tagq.size() > 0 || s_valid); i++) begin
      mb_rden_out = (tagq.size() > 0);
      mb_rddata   = rand_line();
      tick();
    end
    mb_rden_out = 1'b0;
    chk("t4_drained", DW'(outstanding), '0);

    // Interleaved reads 3, 0, 1 (then 2) with in-order returns.
    do_reset(0, "rst5");
    set_req(3, 1'b0, rand_addr()); tick(); idle();
    set_req(0, 1'b0, rand_addr()); tick(); idle();
    set_req(1, 1'b0, rand_addr()); tick(); idle();
    tick();
    chk("t5_three", DW'(outstanding), DW'(6'd3));
    set_req(2, 1'b0, rand_addr());
    mb_rden_out = 1'b1; mb_rddata = rand_line();
    tick();
    rseq[0] = resp_valid;
    chk("t5_outst_a", DW'(outstanding), DW'(6'd2));
    idle();
    mb_rden_out = 1'b1; mb_rddata = rand_line();
    tick();
    rseq[1] = resp_valid;
    chk("t5_pushpop", DW'(outstanding), DW'(6'd2));
    for (int i = 2; i < 4; i++) begin
      mb_rddata = rand_line();
      tick();
      rseq[i] = resp_valid;
    end
    idle();
    chk("t5_seq0", DW'(rseq[0]), DW'(4'b1000));
    chk("t5_seq1", DW'(rseq[1]), DW'(4'b0001));
    chk("t5_seq2", DW'(rseq[2]), DW'(4'b0010));
    chk("t5_seq3", DW'(rseq[3]), DW'(4'b0100));
    chk("t5_empty", DW'(outstanding), '0);

    // Return with an empty tag FIFO.
    do_reset(0, "rst6");
    mb_rden_out = 1'b1; mb_rddata = rand_line();
    tick();
    idle();
    chk("t6_err", DW'(err_underflow), DW'(1'b1));
    chk("t6_no_resp", DW'(resp_valid), '0);
    tick();
    chk("t6_sticky", DW'(err_underflow), DW'(1'b1));

    // Random traffic phases, then an asynchronous reset mid-cycle.
    do_reset(0, "rst7");
    for (int ph = 0; ph < 3; ph++) begin
      for (int t = 0; t < 600; t++) begin
        case (ph)
          0:       rand_inputs(4, 15, 70);
          1:       rand_inputs(50, 25, 60);
          default: rand_inputs(90, 10, 80);
        endcase
        tick();
      end
    end
    rand_inputs(50, 20, 80);
    do_reset(3, "rst_mid");
    for (int t = 0; t < 300; t++) begin
      rand_inputs(40, 20, 70);
      tick();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
